multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It takes the latched instruction fields and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Each cycle it drives the immediate-generator select (EXTOp), the ALU operand selects, the register-file and PC write enables, and the memory request handshake. It also counts retired instructions. It sits between the instruction register and the shared datapath: PC, immediate generator, ALU, register file and unified memory port.

Parameters:
MEM_TIMEOUT, 0, wait-cycle limit for mem_ready before trapping; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], stable from DECODE until the next FETCH
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
br_taken  in  1  branch comparison result from the ALU, valid in EXEC
mem_ready  in  1  memory port completion, single-cycle pulse or level
mem_req  out  1  memory access request
mem_we  out  1  store strobe, valid only with mem_req
addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
ir_we  out  1  instruction-register load
pc_we  out  1  PC update strobe
npc_sel  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = ALU result (jalr)
EXTOp  out  6  immediate select, using the shared EXT_CTRL_* encodings
alu_src_a  out  1  ALU operand A: 0 = rs1, 1 = PC
alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = immediate
wd_sel  out  2  register write data: 00 = ALU, 01 = memory, 10 = PC+4
rf_we  out  1  register-file write strobe
illegal  out  1  sticky trap flag
state  out  3  current state, for debug
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: S_RESET=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_TRAP=6.
- rstn low: state=S_RESET and instret=0 immediately (asynchronous). While rstn is low or state is S_RESET, every output is 0.
- S_RESET: advances to S_FETCH on the first clk edge after rstn rises.
- S_FETCH: mem_req=1, addr_sel=0. Hold until mem_ready. In the mem_ready cycle ir_we=1, and the next state is S_DECODE.
- S_DECODE: decodes opcode. EXTOp becomes valid here and holds through the end of the instruction.
  - EXTOp selection: I-type loads, OP-IMM and jalr give ITYPE. slli/srli/srai (OP-IMM with funct3 001 or 101) give ITYPE_SHAMT. Stores give STYPE, branches BTYPE, lui/auipc UTYPE, jal JTYPE. R-type gives 0.
  - Unknown opcode goes to S_TRAP; otherwise S_EXEC.
- S_EXEC:
  - ALU ops, lui, auipc, jal, jalr: go to S_WB.
  - Load/store: alu_src_b=1, go to S_MEM.
  - Branch: pc_we=1, npc_sel=01 if br_taken else 00, then go to S_FETCH.
- S_MEM: mem_req=1, addr_sel=1, mem_we=1 for stores. Hold until mem_ready.
  - Store: pc_we=1 and npc_sel=00 in the mem_ready cycle, then S_FETCH.
  - Load: go to S_WB.
- S_WB: rf_we=1 and pc_we=1 for exactly one cycle, then S_FETCH.
  - npc_sel=01 for jal, 10 for jalr, else 00.
  - wd_sel=10 for jal/jalr, 01 for loads, else 00.
- rd = x0 is not filtered here; the register file ignores writes to x0.
- pc_we: asserts exactly once per retired instruction. instret increments on that same edge and wraps modulo 2^CNT_W.
- Timeout: with MEM_TIMEOUT>0, if mem_req stays high for MEM_TIMEOUT cycles without mem_ready, the block enters S_TRAP.
- S_TRAP: illegal=1, all other strobes 0. Only rstn exits this state.
- mem_req stays high until mem_ready is sampled. mem_ready while mem_req is low is ignored.
- Outputs are Moore decodes of state plus the opcode/funct3 latched in DECODE. There are no combinational paths from mem_ready except ir_we and pc_we in the completion cycle.
- Reset asserted mid-access (e.g. during S_MEM) aborts the access: mem_req drops immediately and no partial write-back occurs.

Decomposition:
- Opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR), state codes, and npc_sel/wd_sel codes go into ctrl_encode_def.v.
- EXT_CTRL_* encodings are reused from ctrl_encode_def.v.
- One sub-module, imm_sel_decode: combinational opcode/funct3 → EXTOp, plus a legal flag. It is unit-testable on its own.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready one cycle after request → states 1,2,3,5,1. EXTOp=010000, alu_src_b=1, rf_we pulses once in WB, pc_we once with npc_sel=00, instret=1.
- slli x1,x1,2 (0x00209093) → EXTOp=100000 from DECODE through WB. Same cycle count as addi.
- sw x1,0(x3) (0x0011A023), mem_ready delayed 3 cycles in MEM → mem_req and mem_we held 4 cycles, addr_sel=1, EXTOp=001000, rf_we never asserts, pc_we once.
- beq x0,x0,+8 (0x00000463), br_taken=1 → EXTOp=000100, npc_sel=01 with pc_we in EXEC, back to FETCH after 3 states. Repeat with br_taken=0 → npc_sel=00.
- opcode 0x7F (0x0000007F) → S_TRAP after DECODE, illegal=1 sticky for 20 cycles, mem_req stays 0, instret unchanged. rstn low → illegal=0.
- rstn pulsed low during S_MEM of a load → mem_req, rf_we and all other outputs are 0 within the same cycle. Restarts in S_FETCH after S_RESET, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: state codes,
// opcodes, immediate-select one-hots and the next-PC / write-data mux codes.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // One-hot immediate selects shared with the immediate generator.
   localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
   localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
   localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
   localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
   localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
   localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_OFFSET = 2'b01;
   localparam logic [1:0] NPC_ALU    = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   function automatic logic is_shift_imm(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode/funct3 decode to the immediate-generator select,
// plus a legality flag for opcodes this core implements.
module imm_sel_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   output logic [5:0] o_ext_op,
   output logic       o_legal
);

   always_comb begin
      o_ext_op = '0;
      o_legal  = 1'b1;
      case (i_opcode)
         OP_LOAD, OP_JALR: o_ext_op = EXT_CTRL_ITYPE;
         OP_IMM: begin
            if (is_shift_imm(i_funct3)) begin
               o_ext_op = EXT_CTRL_ITYPE_SHAMT;
               // slli has no arithmetic variant; IR[30] set is a reserved encoding
               o_legal  = !((i_funct3 == 3'b001) && i_funct7_5);
            end else begin
               o_ext_op = EXT_CTRL_ITYPE;
            end
         end
         OP_STORE:         o_ext_op = EXT_CTRL_STYPE;
         OP_BRANCH:        o_ext_op = EXT_CTRL_BTYPE;
         OP_LUI, OP_AUIPC: o_ext_op = EXT_CTRL_UTYPE;
         OP_JAL:           o_ext_op = EXT_CTRL_JTYPE;
         OP_REG:           o_ext_op = '0;
         default:          o_legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// handshake, optional access timeout, sticky trap and retired-instruction count.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       npc_sel,
   output logic [5:0]       EXTOp,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic [1:0]       wd_sel,
   output logic             rf_we,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [6:0]       r_opcode;
   logic [2:0]       r_funct3;
   logic             r_funct7_5;
   logic [TO_W-1:0]  r_wait;
   logic [CNT_W-1:0] r_instret;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_funct7_5;
   logic [5:0] w_ext_op;
   logic       w_legal;
   logic       w_is_load, w_is_store, w_is_branch, w_is_imm;
   logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
   logic       w_src_a, w_src_b;
   logic       w_mem_wait, w_timeout;

   // DECODE sees the IR directly; later states use the copy taken in DECODE.
   assign w_opcode   = (r_state == S_DECODE) ? opcode   : r_opcode;
   assign w_funct3   = (r_state == S_DECODE) ? funct3   : r_funct3;
   assign w_funct7_5 = (r_state == S_DECODE) ? funct7_5 : r_funct7_5;

   imm_sel_decode u_imm_sel (
      .i_opcode   (w_opcode),
      .i_funct3   (w_funct3),
      .i_funct7_5 (w_funct7_5),
      .o_ext_op   (w_ext_op),
      .o_legal    (w_legal)
   );

   assign w_is_load   = (w_opcode == OP_LOAD);
   assign w_is_store  = (w_opcode == OP_STORE);
   assign w_is_branch = (w_opcode == OP_BRANCH);
   assign w_is_imm    = (w_opcode == OP_IMM);
   assign w_is_lui    = (w_opcode == OP_LUI);
   assign w_is_auipc  = (w_opcode == OP_AUIPC);
   assign w_is_jal    = (w_opcode == OP_JAL);
   assign w_is_jalr   = (w_opcode == OP_JALR);

   // Operand selects hold from EXEC through WB so the ALU result stays valid.
   assign w_src_a = w_is_auipc;
   assign w_src_b = w_is_imm | w_is_load | w_is_store | w_is_lui | w_is_auipc | w_is_jalr;

   assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_timeout  = (MEM_TIMEOUT > 0) && w_mem_wait && !mem_ready &&
                       (r_wait == TO_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_opcode   <= '0;
         r_funct3   <= '0;
         r_funct7_5 <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_opcode   <= opcode;
         r_funct3   <= funct3;
         r_funct7_5 <= funct7_5;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wait <= '0;
      end else if (w_mem_wait && !mem_ready && !w_timeout) begin
         r_wait <= r_wait + TO_W'(1);
      end else begin
         r_wait <= '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_instret <= '0;
      end else if (pc_we) begin
         r_instret <= r_instret + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      addr_sel     = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      npc_sel      = NPC_PLUS4;
      EXTOp        = '0;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      wd_sel       = WD_ALU;
      rf_we        = 1'b0;
      illegal      = 1'b0;
      case (r_state)
         S_RESET: w_state_next = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we        = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next = S_TRAP;
            end
         end
         S_DECODE: begin
            EXTOp        = w_ext_op;
            w_state_next = w_legal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            EXTOp     = w_ext_op;
            alu_src_a = w_src_a;
            alu_src_b = w_src_b;
            if (w_is_load || w_is_store) begin
               w_state_next = S_MEM;
            end else if (w_is_branch) begin
               pc_we        = 1'b1;
               npc_sel      = br_taken ? NPC_OFFSET : NPC_PLUS4;
               w_state_next = S_FETCH;
            end else begin
               w_state_next = S_WB;
            end
         end
         S_MEM: begin
            EXTOp     = w_ext_op;
            alu_src_a = w_src_a;
            alu_src_b = w_src_b;
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = w_is_store;
            if (mem_ready) begin
               if (w_is_store) begin
                  pc_we        = 1'b1;
                  w_state_next = S_FETCH;
               end else begin
                  w_state_next = S_WB;
               end
            end else if (w_timeout) begin
               w_state_next = S_TRAP;
            end
         end
         S_WB: begin
            EXTOp     = w_ext_op;
            alu_src_a = w_src_a;
            alu_src_b = w_src_b;
            rf_we     = 1'b1;
            pc_we     = 1'b1;
            if (w_is_jal) begin
               npc_sel = NPC_OFFSET;
            end else if (w_is_jalr) begin
               npc_sel = NPC_ALU;
            end
            if (w_is_jal || w_is_jalr) begin
               wd_sel = WD_PC4;
            end else if (w_is_load) begin
               wd_sel = WD_MEM;
            end
            w_state_next = S_FETCH;
         end
         S_TRAP:  illegal = 1'b1;
         default: w_state_next = S_RESET;
      endcase
   end

   assign state   = r_state;
   assign instret = r_instret;

endmodule
